// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - data-side bus controller: RAM wait-state sequencer plus switch/LED/timer I/O
module data_bus_ctrl #(
   parameter int unsigned RAM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_den,
   input  logic        cpu_drw,
   input  logic [31:0] cpu_daddr,
   input  logic [31:0] cpu_dout,
   output logic [31:0] cpu_din,
   output logic        cpu_stall,
   output logic        ram_en,
   output logic        ram_we,
   output logic [21:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic [7:0]  sw,
   output logic [7:0]  led
);

   // I/O register word addresses (byte address >> 2)
   localparam logic [29:0] SW_WADDR    = 30'h3C04_0000;
   localparam logic [29:0] LED_WADDR   = 30'h3C08_0000;
   localparam logic [29:0] TIMER_WADDR = 30'h3C18_0000;
   localparam logic [7:0]  RAM_REGION  = 8'h10;
   localparam logic [3:0]  WAIT_INIT   = 4'(RAM_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] rdata_q;
   logic        ram_en_q;
   logic        ram_we_q;
   logic [21:0] ram_addr_q;
   logic [31:0] ram_wdata_q;

   logic [31:0] timer_q;
   logic [31:0] timer_d;
   logic [7:0]  led_q;
   logic [7:0]  led_d;
   logic [7:0]  sw_meta_q;
   logic [7:0]  sw_sync_q;

   logic        ram_hit;
   logic        sw_hit;
   logic        led_hit;
   logic        timer_hit;
   logic        ram_req;
   logic        io_wr;
   logic [31:0] io_rdata;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^cpu_daddr[1:0];

   assign ram_hit   = (cpu_daddr[31:24] == RAM_REGION);
   assign sw_hit    = (cpu_daddr[31:2] == SW_WADDR);
   assign led_hit   = (cpu_daddr[31:2] == LED_WADDR);
   assign timer_hit = (cpu_daddr[31:2] == TIMER_WADDR);
   assign ram_req   = cpu_den & ram_hit;

   // Stall is gated by rst so a RAM request held on the bus during reset cannot freeze the CPU.
   assign cpu_stall = rst & (((state_q == ST_IDLE) & ram_req) | (state_q == ST_WAIT));
   assign io_wr     = cpu_den & cpu_drw & ~cpu_stall;

   always_comb begin
      io_rdata = 32'h0;
      if (sw_hit) begin
         io_rdata = {24'h0, sw_sync_q};
      end else if (led_hit) begin
         io_rdata = {24'h0, led_q};
      end else if (timer_hit) begin
         io_rdata = timer_q;
      end
   end

   assign cpu_din = (state_q == ST_DONE) ? rdata_q : io_rdata;

   always_comb begin
      led_d = led_q;
      if (io_wr && led_hit) begin
         led_d = cpu_dout[7:0];
      end
   end

   // A write lands on the edge and the increment resumes from the written value next cycle.
   always_comb begin
      timer_d = timer_q + 32'd1;
      if (io_wr && timer_hit) begin
         timer_d = cpu_dout;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q   <= 32'h0;
         led_q     <= 8'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
      end else begin
         timer_q   <= timer_d;
         led_q     <= led_d;
         sw_meta_q <= sw;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'h0;
         rdata_q     <= 32'h0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= 22'h0;
         ram_wdata_q <= 32'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ram_req) begin
                  ram_addr_q  <= cpu_daddr[23:2];
                  ram_wdata_q <= cpu_dout;
                  ram_we_q    <= cpu_drw;
                  ram_en_q    <= 1'b1;
                  cnt_q       <= WAIT_INIT;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'h0) begin
                  rdata_q  <= ram_rdata;
                  ram_en_q <= 1'b0;
                  ram_we_q <= 1'b0;
                  state_q  <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'h1;
               end
            end
            ST_DONE: begin
               // The completed request is still on the bus here; it must not be re-accepted.
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign led       = led_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb/tb_data_bus_ctrl.sv - directed vector bench for data_bus_ctrl
module tb_data_bus_ctrl;

   localparam logic [31:0] A_SW    = 32'hF010_0000;
   localparam logic [31:0] A_LED   = 32'hF020_0000;
   localparam logic [31:0] A_TIMER = 32'hF060_0000;

   logic        clk;
   logic        rst;
   logic        cpu_den;
   logic        cpu_drw;
   logic [31:0] cpu_daddr;
   logic [31:0] cpu_dout;
   logic [31:0] cpu_din;
   logic        cpu_stall;
   logic        ram_en;
   logic        ram_we;
   logic [21:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [7:0]  sw;
   logic [7:0]  led;

   int n_cmp;
   int n_bad;

   data_bus_ctrl #(.RAM_WAIT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_den   (cpu_den),
      .cpu_drw   (cpu_drw),
      .cpu_daddr (cpu_daddr),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .cpu_stall (cpu_stall),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sw        (sw),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: combinational read, write on enabled edges, preloaded while rst is low
   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[4] <= 32'hDEAD_BEEF;
      end else if (ram_en && ram_we) begin
         mem[ram_addr[3:0]] <= ram_wdata;
      end
   end
   assign ram_rdata = mem[ram_addr[3:0]];

   typedef struct {
      logic        den;
      logic        drw;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [7:0]  sw;
      logic [31:0] exp_din;
      logic        exp_stall;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ram_access(input logic drw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [21:0] exp_addr,
                             output int stalls, output int en_cnt, output int we_cnt,
                             output logic [31:0] din, output logic first_stall,
                             output logic wd_ok, output logic addr_ok);
      bit done;
      done        = 0;
      stalls      = 0;
      en_cnt      = 0;
      we_cnt      = 0;
      din         = 32'hX;
      first_stall = 1'b0;
      wd_ok       = 1'b1;
      addr_ok     = 1'b1;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         cpu_den   = 1'b1;
         cpu_drw   = drw;
         cpu_daddr = addr;
         cpu_dout  = wdata;
         #1;
         if (k == 0) first_stall = cpu_stall;
         if (ram_en) begin
            en_cnt++;
            if (ram_addr !== exp_addr) addr_ok = 1'b0;
            if (ram_we) begin
               we_cnt++;
               if (ram_wdata !== wdata) wd_ok = 1'b0;
            end
         end
         if (!cpu_stall) begin
            din  = cpu_din;
            done = 1;
         end else begin
            stalls++;
         end
      end
      if (!done) stalls = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          st;
      int          ec;
      int          wc;
      logic [31:0] d;
      logic        fs;
      logic        wok;
      logic        aok;

      n_cmp = 0;
      n_bad = 0;

      // Reset held with a RAM request on the bus
      rst       = 1'b0;
      cpu_den   = 1'b1;
      cpu_drw   = 1'b0;
      cpu_daddr = 32'h1000_0000;
      cpu_dout  = 32'h0;
      sw        = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("rst_stall", {31'h0, cpu_stall}, 32'h0);
         check("rst_led", {24'h0, led}, 32'h0);
         check("rst_ram_en", {31'h0, ram_en}, 32'h0);
      end
      @(negedge clk);
      rst       = 1'b1;
      cpu_daddr = A_TIMER;
      #1;
      check("timer_after_rst", cpu_din, 32'h0);
      repeat (5) @(negedge clk);
      #1;
      check("timer_plus5", cpu_din, 32'd5);

      // I/O vectors: {den, drw, addr, dout, sw, exp_din, exp_stall, exp_led}
      vecs[0]  = '{1'b1, 1'b1, A_LED,         32'h0000_01A5, 8'h00, 32'h0000_0000, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, A_LED,         32'h0,         8'h00, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[2]  = '{1'b1, 1'b0, A_SW,          32'h0,         8'h3C, 32'h0000_0000, 1'b0, 8'hA5};
      vecs[3]  = '{1'b1, 1'b0, A_SW,          32'h0,         8'h3C, 32'h0000_0000, 1'b0, 8'hA5};
      vecs[4]  = '{1'b1, 1'b0, A_SW,          32'h0,         8'h3C, 32'h0000_003C, 1'b0, 8'hA5};
      vecs[5]  = '{1'b1, 1'b1, 32'h2000_0000, 32'hFFFF_FFFF, 8'h3C, 32'h0000_0000, 1'b0, 8'hA5};
      vecs[6]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         8'h3C, 32'h0000_0000, 1'b0, 8'hA5};
      vecs[7]  = '{1'b1, 1'b0, A_LED,         32'h0,         8'h3C, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[8]  = '{1'b1, 1'b1, A_SW,          32'h0,         8'h3C, 32'h0000_003C, 1'b0, 8'hA5};
      vecs[9]  = '{1'b1, 1'b0, A_SW,          32'h0,         8'h3C, 32'h0000_003C, 1'b0, 8'hA5};
      vecs[10] = '{1'b0, 1'b1, A_LED,         32'h0000_0055, 8'h3C, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[11] = '{1'b1, 1'b0, A_LED,         32'h0,         8'h3C, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[12] = '{1'b1, 1'b0, 32'hF020_0003, 32'h0,         8'h3C, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[13] = '{1'b1, 1'b1, 32'hF020_0002, 32'h0000_FF00, 8'h3C, 32'h0000_00A5, 1'b0, 8'hA5};
      vecs[14] = '{1'b1, 1'b0, A_LED,         32'h0,         8'h3C, 32'h0000_0000, 1'b0, 8'h00};
      vecs[15] = '{1'b1, 1'b0, 32'hF020_0004, 32'h0,         8'h3C, 32'h0000_0000, 1'b0, 8'h00};

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         cpu_den   = vecs[i].den;
         cpu_drw   = vecs[i].drw;
         cpu_daddr = vecs[i].addr;
         cpu_dout  = vecs[i].dout;
         sw        = vecs[i].sw;
         #1;
         check($sformatf("vec%0d_din", i), cpu_din, vecs[i].exp_din);
         check($sformatf("vec%0d_stall", i), {31'h0, cpu_stall}, {31'h0, vecs[i].exp_stall});
         check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
      end

      // Timer write then wrap
      @(negedge clk);
      cpu_den   = 1'b1;
      cpu_drw   = 1'b1;
      cpu_daddr = A_TIMER;
      cpu_dout  = 32'hFFFF_FFFE;
      @(negedge clk);
      cpu_drw = 1'b0;
      #1;
      check("timer_written", cpu_din, 32'hFFFF_FFFE);
      @(negedge clk);
      #1;
      check("timer_max", cpu_din, 32'hFFFF_FFFF);
      @(negedge clk);
      #1;
      check("timer_wrap", cpu_din, 32'h0000_0000);

      // RAM read
      ram_access(1'b0, 32'h1000_0010, 32'h0, 22'h000004, st, ec, wc, d, fs, wok, aok);
      check("rd_stalls", st, 4);
      check("rd_en_cycles", ec, 3);
      check("rd_addr", {31'h0, aok}, 32'h1);
      check("rd_din", d, 32'hDEAD_BEEF);
      @(negedge clk);
      cpu_den = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("no_retrigger_en", {31'h0, ram_en}, 32'h0);
         check("no_retrigger_stall", {31'h0, cpu_stall}, 32'h0);
         @(negedge clk);
      end

      // RAM write followed back-to-back by a read of the same word
      ram_access(1'b1, 32'h1000_0020, 32'h1234_5678, 22'h000008, st, ec, wc, d, fs, wok, aok);
      check("wr_first_stall", {31'h0, fs}, 32'h1);
      check("wr_stalls", st, 4);
      check("wr_we_cycles", wc, 3);
      check("wr_wdata", {31'h0, wok}, 32'h1);
      check("wr_addr", {31'h0, aok}, 32'h1);
      ram_access(1'b0, 32'h1000_0020, 32'h0, 22'h000008, st, ec, wc, d, fs, wok, aok);
      check("b2b_first_stall", {31'h0, fs}, 32'h1);
      check("b2b_stalls", st, 4);
      check("b2b_we_cycles", wc, 0);
      check("b2b_din", d, 32'h1234_5678);

      // Reset in the middle of a RAM access
      @(negedge clk);
      cpu_den   = 1'b1;
      cpu_drw   = 1'b0;
      cpu_daddr = 32'h1000_0020;
      @(negedge clk);
      #1;
      check("mid_en_before", {31'h0, ram_en}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_en_async", {31'h0, ram_en}, 32'h0);
      check("mid_stall_async", {31'h0, cpu_stall}, 32'h0);
      @(negedge clk);
      cpu_den = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_stall", {31'h0, cpu_stall}, 32'h0);
      ram_access(1'b0, 32'h1000_0010, 32'h0, 22'h000004, st, ec, wc, d, fs, wok, aok);
      check("post_rst_stalls", st, 4);
      check("post_rst_din", d, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
